// File: rtl/seg_capture.sv
// rtl/seg_capture.sv - capture and decode of a scanned 4-digit 7-segment bus; SEG_CAPTURE_DP_EN adds decimal points
module seg_capture #(
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       clk_50MHZ,
  input  logic       rst_n,
  input  logic [6:0] duan_in,
  input  logic [3:0] wei_in,
`ifdef SEG_CAPTURE_DP_EN
  input  logic       dp_in,
  output logic [3:0] dp_out,
`endif
  output logic [3:0] out_1,
  output logic [3:0] out_2,
  output logic [3:0] out_3,
  output logic [3:0] out_4,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       err_code,
  output logic [7:0] err_cnt,
  output logic       stale
);

`ifdef SEG_CAPTURE_DP_EN
  localparam int SW = 12;
  logic [SW-1:0] raw;
  assign raw = {dp_in, wei_in, duan_in};
`else
  localparam int SW = 11;
  logic [SW-1:0] raw;
  assign raw = {wei_in, duan_in};
`endif

  localparam logic [15:0] STABLE_M1  = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] STABLE_MAX = 16'(STABLE_CYCLES);
  localparam logic [23:0] TIMEOUT_M1 = 24'(TIMEOUT_CYCLES - 1);

  logic [SW-1:0] s1, s2, s_prev;
  logic [15:0]   cnt;
  logic          armed;
  logic          accept, slot_hit, legal;
  logic [1:0]    slot_idx;
  logic [3:0]    val;

  logic          acc_q, acc_legal;
  logic [1:0]    acc_slot;
  logic [3:0]    acc_val;
  logic [3:0]    seen_mask, seen_set;
  logic [23:0]   tcnt;
`ifdef SEG_CAPTURE_DP_EN
  logic          acc_dp;
`endif

  // Decode from s_prev: it still holds the stable value even if S moved this cycle.
  always_comb begin
    slot_hit = 1'b1;
    slot_idx = 2'd0;
    case (s_prev[10:7])
      4'b1110: slot_idx = 2'd0;
      4'b1101: slot_idx = 2'd1;
      4'b1011: slot_idx = 2'd2;
      4'b0111: slot_idx = 2'd3;
      default: slot_hit = 1'b0;
    endcase
    legal = 1'b1;
    val   = 4'd0;
    case (s_prev[6:0])
      7'b0000001: val = 4'd0;
      7'b1001111: val = 4'd1;
      7'b0010010: val = 4'd2;
      7'b0000110: val = 4'd3;
      7'b1001100: val = 4'd4;
      7'b0100100: val = 4'd5;
      7'b0100000: val = 4'd6;
      7'b0001111: val = 4'd7;
      7'b0000000: val = 4'd8;
      7'b0000100: val = 4'd9;
      default:    legal = 1'b0;
    endcase
    accept   = armed && (cnt == STABLE_M1) && slot_hit;
    seen_set = seen_mask | (4'b0001 << acc_slot);
  end

  always_ff @(posedge clk_50MHZ or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      s_prev    <= '0;
      cnt       <= '0;
      armed     <= 1'b0;
      acc_q     <= 1'b0;
      acc_legal <= 1'b0;
      acc_slot  <= 2'd0;
      acc_val   <= 4'd0;
`ifdef SEG_CAPTURE_DP_EN
      acc_dp    <= 1'b0;
`endif
    end else begin
      s1     <= raw;
      s2     <= s1;
      s_prev <= s2;
      if (s2 != s_prev) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else begin
        if (cnt != STABLE_MAX) cnt <= cnt + 16'd1;
        if (accept) armed <= 1'b0;
      end
      acc_q     <= accept;
      acc_legal <= legal;
      acc_slot  <= slot_idx;
      acc_val   <= val;
`ifdef SEG_CAPTURE_DP_EN
      acc_dp    <= ~s_prev[11];
`endif
    end
  end

  // An accept always takes priority over a coincident timeout.
  always_ff @(posedge clk_50MHZ or negedge rst_n) begin
    if (!rst_n) begin
      out_1       <= 4'd0;
      out_2       <= 4'd0;
      out_3       <= 4'd0;
      out_4       <= 4'd0;
      digit_valid <= 4'd0;
      frame_done  <= 1'b0;
      err_code    <= 1'b0;
      err_cnt     <= 8'd0;
      stale       <= 1'b0;
      seen_mask   <= 4'd0;
      tcnt        <= 24'd0;
`ifdef SEG_CAPTURE_DP_EN
      dp_out      <= 4'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      err_code   <= 1'b0;
      if (acc_q) begin
        tcnt <= 24'd0;
        if (acc_legal) begin
          case (acc_slot)
            2'd0: out_1 <= acc_val;
            2'd1: out_2 <= acc_val;
            2'd2: out_3 <= acc_val;
            default: out_4 <= acc_val;
          endcase
          digit_valid[acc_slot] <= 1'b1;
          stale <= 1'b0;
`ifdef SEG_CAPTURE_DP_EN
          dp_out[acc_slot] <= acc_dp;
`endif
          if (seen_set == 4'b1111) begin
            frame_done <= 1'b1;
            seen_mask  <= 4'd0;
          end else begin
            seen_mask <= seen_set;
          end
        end else begin
          err_code <= 1'b1;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
      end else if (tcnt == TIMEOUT_M1) begin
        stale       <= 1'b1;
        digit_valid <= 4'd0;
        seen_mask   <= 4'd0;
      end else begin
        tcnt <= tcnt + 24'd1;
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// tb/tb_seg_capture.sv - directed scoreboard bench for seg_capture (STABLE_CYCLES=4, TIMEOUT_CYCLES=64)
module tb_seg_capture;

  logic       clk_50MHZ = 1'b0;
  logic       rst_n     = 1'b0;
  logic [6:0] duan_in   = 7'b1111111;
  logic [3:0] wei_in    = 4'b1111;
  logic [3:0] out_1, out_2, out_3, out_4, digit_valid;
  logic       frame_done, err_code, stale;
  logic [7:0] err_cnt;
`ifdef SEG_CAPTURE_DP_EN
  logic       dp_in = 1'b1;
  logic [3:0] dp_out;
`endif

  seg_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk_50MHZ   (clk_50MHZ),
    .rst_n       (rst_n),
    .duan_in     (duan_in),
    .wei_in      (wei_in),
`ifdef SEG_CAPTURE_DP_EN
    .dp_in       (dp_in),
    .dp_out      (dp_out),
`endif
    .out_1       (out_1),
    .out_2       (out_2),
    .out_3       (out_3),
    .out_4       (out_4),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .err_code    (err_code),
    .err_cnt     (err_cnt),
    .stale       (stale)
  );

  always #10 clk_50MHZ = ~clk_50MHZ;

  int cyc = 0;
  int fd_count = 0;
  int fd_cyc = 0;
  int ec_count = 0;

  always @(posedge clk_50MHZ) cyc <= cyc + 1;

  always @(negedge clk_50MHZ) begin
    if (frame_done === 1'b1) begin
      fd_count <= fd_count + 1;
      fd_cyc   <= cyc;
    end
    if (err_code === 1'b1) ec_count <= ec_count + 1;
  end

  typedef struct {
    string      tag;
    logic [3:0] o1, o2, o3, o4, dv;
    logic [7:0] ec;
    logic       st;
  } exp_t;

  exp_t sbq[$];
  logic [3:0] m_o1 = 0, m_o2 = 0, m_o3 = 0, m_o4 = 0, m_dv = 0;
  logic [7:0] m_ec = 0;
  logic       m_st = 0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag; e.o1 = m_o1; e.o2 = m_o2; e.o3 = m_o3; e.o4 = m_o4;
    e.dv = m_dv; e.ec = m_ec; e.st = m_st;
    sbq.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk({e.tag, " out_1"}, 32'(out_1), 32'(e.o1));
    chk({e.tag, " out_2"}, 32'(out_2), 32'(e.o2));
    chk({e.tag, " out_3"}, 32'(out_3), 32'(e.o3));
    chk({e.tag, " out_4"}, 32'(out_4), 32'(e.o4));
    chk({e.tag, " digit_valid"}, 32'(digit_valid), 32'(e.dv));
    chk({e.tag, " err_cnt"}, 32'(err_cnt), 32'(e.ec));
    chk({e.tag, " stale"}, 32'(stale), 32'(e.st));
  endtask

  task automatic hold(input logic [3:0] w, input logic [6:0] d, input int n);
    wei_in  = w;
    duan_in = d;
    repeat (n) @(negedge clk_50MHZ);
  endtask

  int fd0, ec0, c4;

  initial begin
    // reset and idle blanking
    repeat (3) @(negedge clk_50MHZ);
    push("reset");
    #1 pop_check();
    chk("reset frame_done", 32'(frame_done), 32'd0);
    chk("reset err_code", 32'(err_code), 32'd0);
    @(negedge clk_50MHZ);
    rst_n = 1'b1;
    repeat (63) @(negedge clk_50MHZ);
    #1 chk("stale before 64", 32'(stale), 32'd0);
    @(negedge clk_50MHZ);
    #1 chk("stale at 64", 32'(stale), 32'd1);
    m_st = 1'b1;
    push("idle");
    repeat (36) @(negedge clk_50MHZ);
    #1 pop_check();
    chk("idle frame pulses", fd_count, 0);
    chk("idle err pulses", ec_count, 0);

    // full frame 3,7,0,9
    fd0 = fd_count;
    hold(4'b1110, 7'b0000110, 10);
    hold(4'b1101, 7'b0001111, 10);
    hold(4'b1011, 7'b0000001, 10);
    c4 = cyc + 1;
    hold(4'b0111, 7'b0000100, 10);
    m_o1 = 3; m_o2 = 7; m_o3 = 0; m_o4 = 9; m_dv = 4'b1111; m_st = 0;
    push("frame1");
    #1 pop_check();
    chk("frame1 pulses", fd_count - fd0, 1);
    chk("frame1 pulse edge", fd_cyc, c4 + 7);

    // illegal pattern, then saturation
    ec0 = ec_count;
    hold(4'b1101, 7'b1111110, 10);
    m_ec = 1;
    push("illegal1");
    #1 pop_check();
    chk("illegal1 pulses", ec_count - ec0, 1);
    for (int i = 0; i < 300; i++)
      hold((i % 2 == 0) ? 4'b1011 : 4'b1101, 7'b1111110, 5);
    hold(4'b1111, 7'b1111111, 10);
    m_ec = 8'd255;
    push("illegal_sat");
    #1 pop_check();
    chk("illegal pulses total", ec_count - ec0, 301);

    // glitch shorter than the window, then a proper slot
    ec0 = ec_count;
    fd0 = fd_count;
    hold(4'b1110, 7'b0100100, 3);
    hold(4'b1111, 7'b1111111, 5);
    push("glitch");
    #1 pop_check();
    hold(4'b1110, 7'b0100100, 10);
    m_o1 = 5;
    push("slot1_5");
    #1 pop_check();
    chk("glitch err pulses", ec_count - ec0, 0);
    chk("glitch frame pulses", fd_count - fd0, 0);

    // complete the frame, then time out
    hold(4'b1101, 7'b1001111, 10);
    hold(4'b1011, 7'b0010010, 10);
    hold(4'b0111, 7'b1001100, 10);
    m_o2 = 1; m_o3 = 2; m_o4 = 4;
    push("frame2");
    #1 pop_check();
    chk("frame2 pulses", fd_count - fd0, 1);
    hold(4'b1111, 7'b1111111, 70);
    m_dv = 4'b0000; m_st = 1;
    push("timeout");
    #1 pop_check();
    hold(4'b1011, 7'b0000000, 10);
    m_o3 = 8; m_dv = 4'b0100; m_st = 0;
    push("after_stale");
    #1 pop_check();

    // reset in the middle of a stable slot-4 window
    hold(4'b0111, 7'b0010010, 4);
    rst_n = 1'b0;
    m_o1 = 0; m_o2 = 0; m_o3 = 0; m_o4 = 0; m_dv = 0; m_ec = 0; m_st = 0;
    push("mid_reset");
    #1 pop_check();
    chk("mid_reset frame_done", 32'(frame_done), 32'd0);
    @(negedge clk_50MHZ);
    @(negedge clk_50MHZ);
    rst_n = 1'b1;
    push("post_reset_7");
    repeat (7) @(negedge clk_50MHZ);
    #1 pop_check();
    @(negedge clk_50MHZ);
    m_o4 = 2; m_dv = 4'b1000;
    push("post_reset_8");
    #1 pop_check();

`ifdef SEG_CAPTURE_DP_EN
    dp_in = 1'b0;
    hold(4'b1101, 7'b1001111, 10);
    #1 chk("dp_out slot2", 32'(dp_out), 32'b0010);
    chk("dp out_2", 32'(out_2), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_capture.md
Name: seg_capture

Overview:
- Receive-side counterpart of the 4-digit multiplexed 7-segment driver.
- Samples the scanned segment bus (`duan`, active-low, a..g on bits 6..0) and the digit-select bus (`wei`, active-low one-hot).
- Debounces each scan slot, decodes the segment pattern back to a 4-bit digit, and holds all four digits.
- Used for board loopback self-test and for reading an external multiplexed display.

Parameters:
- STABLE_CYCLES, 1024: consecutive identical synchronized samples required before a scan slot is accepted; range 2..65535.
- TIMEOUT_CYCLES, 1048576: clocks without any acceptance before the display is declared stale; range 16..2^24.

Ports:
- clk_50MHZ  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- duan_in  input  7  segment bus, active-low, bit6=a ... bit0=g
- wei_in  input  4  digit select, active-low; 1110=digit1, 1101=digit2, 1011=digit3, 0111=digit4
- out_1..out_4  output  4 each  last decoded value per digit
- digit_valid  output  4  bit k-1 set when out_k holds a legally decoded value
- frame_done  output  1  one-cycle pulse when all four digits are accepted since the last frame
- err_code  output  1  one-cycle pulse on acceptance of an illegal segment pattern
- err_cnt  output  8  saturating count of err_code pulses
- stale  output  1  no acceptance for TIMEOUT_CYCLES clocks

Behaviour:
- Reset: asynchronous, active-low. All outputs are 0: out_1..out_4=0, digit_valid=0000, frame_done=0, err_code=0, err_cnt=0, stale=0. Sync flops, stability counter, seen mask and timeout counter are also cleared.
- Synchronizer:
  - {wei_in,duan_in} passes through a 2-flop synchronizer, giving sample S.
  - S_prev holds the previous cycle's S.
- Stability counter (16 bit):
  - If S != S_prev, cleared to 0 and the armed flag is set to 1.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Accept condition: counter == STABLE_CYCLES-1, armed=1, and S.wei is exactly one of the four one-hot-low codes.
  - armed is cleared on accept, so each stable slot is accepted exactly once.
  - wei=1111 or multiple-low codes are blanking: no accept, no error.
- Latency: outputs update exactly STABLE_CYCLES+3 rising edges after a new input value is first captured by sync stage 1.
- Decode table (duan → value):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4
  - 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9
  - Any other pattern is illegal.
- Legal accept on slot k:
  - out_k and digit_valid[k-1] are registered on the next edge.
  - seen_mask[k-1] is set.
- Illegal accept:
  - out_k and digit_valid are unchanged.
  - err_code pulses 1 cycle; err_cnt increments, saturating at 255.
  - seen_mask is not set.
- Frame completion:
  - When seen_mask becomes 1111, frame_done pulses 1 cycle (the same edge out_k updates) and seen_mask clears.
  - Repeated accepts of an already-seen digit keep updating out_k but do not pulse frame_done.
- Timeout counter (24 bit):
  - Cleared on every accept (legal or illegal), otherwise increments.
  - Reaching TIMEOUT_CYCLES sets stale=1, clears digit_valid and seen_mask, and holds the counter.
  - out_k values are retained.
  - stale clears on the edge of the next legal accept.
- Reset mid-slot: all state is discarded; the first accept after reset needs a full STABLE_CYCLES window.
- Simultaneous events: accept and timeout in the same cycle → accept wins; the counter clears and stale is not set.

Optional Feature:
- Macro: SEG_CAPTURE_DP_EN.
- Defined:
  - Adds port dp_in (input 1, active-low decimal point) and dp_out (output 4, reset 0000).
  - dp_in is synchronized and included in S for the stability compare.
  - On a legal accept of slot k, dp_out[k-1] <= ~dp_in_sync.
- Undefined: no dp ports, no extra flops; behaviour is otherwise identical.

Test Plan:
- Bench configuration: STABLE_CYCLES=4, TIMEOUT_CYCLES=64.
- Reset release, inputs wei=1111, duan=1111111 held 100 cycles → all outputs 0, no accepts, stale=1 at cycle 64 after reset.
- Drive slots 1..4 with digits 3,7,0,9, each held 10 cycles → out_1..out_4=3,7,0,9; digit_valid=1111; stale=0; exactly one frame_done pulse, on the 4th accept edge, exactly 7 edges after slot-4 input.
- Slot 2 with duan=1111110 (illegal) → err_code pulses once, err_cnt=1, out_2 unchanged. Then 300 illegal slots → err_cnt=255, holding.
- Glitch: slot 1 digit 5 held 3 cycles then changed → no accept. Then slot 1 digit 5 held 4+ cycles → exactly one accept, out_1=5.
- After a full frame, hold wei=1111 for 64 cycles → stale=1, digit_valid=0000, out_k retained. Next legal slot-3 digit 8 → stale=0, digit_valid=0100, out_3=8.
- Assert rst_n low mid-way through a stable slot-4 window → all outputs 0 immediately. After release, a full 4-cycle window is required before the slot is accepted.
- With SEG_CAPTURE_DP_EN: slot 2 digit 1 with dp_in=0 → dp_out=0010.
